bus_arbiter_reg: RTL and testbench

Registered, parametrised bus arbiter for the SAP datapath. It replaces the fixed five-source combinational bus mux with N generic sources of configurable width and fixed priority, and adds a one-cycle registered bus. It also provides sticky multi-driver conflict detection, a transfer counter, and an optional conflict trap. It sits between every bus-driving register (PC, RAM, IR operand, accumulator, ALU) and every bus-loading register (MAR, IR, A, B, OUT).

---
 rtl/bus_arbiter_reg.sv | 135 +++++++++++++
 tb/tb_bus_arbiter_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_arbiter_reg                                                 |
// | Purpose  : Registered fixed-priority N-source bus with sticky conflict     |
// |            status and a saturating transfer counter. Optional conflict     |
// |            trap FSM is enabled by defining BUS_CONFLICT_TRAP_EN.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bus_arbiter_reg #(
  parameter  int N_SRC     = 5,
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = 4,
  parameter  int CNT_W     = 16,
  parameter  int IDLE_HOLD = 0,
  localparam int SRC_IDX_W = (N_SRC <= 2) ? 1 : $clog2(N_SRC)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_SRC*DATA_W-1:0]   src_data_i,
  input  logic [N_SRC-1:0]          src_en_i,
  input  logic                      conflict_clr_i,
  input  logic                      cnt_clr_i,
  output logic [DATA_W-1:0]         bus_o,
  output logic [ADDR_W-1:0]         mar_o,
  output logic                      bus_valid_o,
  output logic [SRC_IDX_W-1:0]      bus_src_o,
  output logic                      conflict_o,
  output logic [N_SRC-1:0]          conflict_mask_o,
  output logic [CNT_W-1:0]          xfer_cnt_o
);

  logic [DATA_W-1:0]    r_bus;
  logic                 r_valid;
  logic [SRC_IDX_W-1:0] r_src;
  logic                 r_conflict;
  logic [N_SRC-1:0]     r_mask;
  logic [CNT_W-1:0]     r_cnt;

  logic [SRC_IDX_W-1:0] w_win_idx;
  logic [DATA_W-1:0]    w_win_data;
  logic                 w_any;
  logic                 w_multi;
  logic                 w_arb_en;
  logic                 w_grant;

  // Scan from the top down so the lowest-index requester is the last writer.
  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (src_en_i[k]) begin
        w_win_idx  = SRC_IDX_W'(k);
        w_win_data = src_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_any   = |src_en_i;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi = |(src_en_i & (src_en_i - N_SRC'(1)));

`ifdef BUS_CONFLICT_TRAP_EN
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t r_state;

  // A clean clear releases the trap and lets this edge's grant through.
  assign w_arb_en = (r_state == RUN) || (conflict_clr_i && !w_multi);
`else
  assign w_arb_en = 1'b1;
`endif

  assign w_grant = w_arb_en && w_any;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_src      <= '0;
      r_conflict <= 1'b0;
      r_mask     <= '0;
      r_cnt      <= '0;
`ifdef BUS_CONFLICT_TRAP_EN
      r_state    <= RUN;
`endif
    end else begin
      if (w_grant) begin
        r_bus   <= w_win_data;
        r_valid <= 1'b1;
        r_src   <= w_win_idx;
      end else begin
        r_valid <= 1'b0;
        if (w_arb_en && (IDLE_HOLD == 0)) begin
          r_bus <= '0;
        end
      end

      if (cnt_clr_i) begin
        r_cnt <= w_grant ? CNT_W'(1) : '0;
      end else if (w_grant && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Set beats clear: a colliding clear restarts the mask from this cycle.
      if (w_multi) begin
        r_conflict <= 1'b1;
        r_mask     <= conflict_clr_i ? src_en_i : (r_mask | src_en_i);
      end else if (conflict_clr_i) begin
        r_conflict <= 1'b0;
        r_mask     <= '0;
      end

`ifdef BUS_CONFLICT_TRAP_EN
      case (r_state)
        RUN:     if (w_multi) r_state <= TRAP;
        TRAP:    if (conflict_clr_i && !w_multi) r_state <= RUN;
        default: r_state <= RUN;
      endcase
`endif
    end
  end

  assign bus_o           = r_bus;
  assign mar_o           = r_bus[ADDR_W-1:0];
  assign bus_valid_o     = r_valid;
  assign bus_src_o       = r_src;
  assign conflict_o      = r_conflict;
  assign conflict_mask_o = r_mask;
  assign xfer_cnt_o      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bus_arbiter_reg                                              |
// | Purpose  : Bench for bus_arbiter_reg: directed vector table, counter and   |
// |            reset sequences, randomized traffic against a reference model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_bus_arbiter_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] src_data = '0;
  logic [4:0]  src_en = '0;
  logic        cclr = 1'b0;
  logic        nclr = 1'b0;

  logic [7:0]  bus0, bus1;
  logic [3:0]  mar0, mar1;
  logic        valid0, valid1;
  logic [2:0]  src0, src1;
  logic        conf0, conf1;
  logic [4:0]  mask0, mask1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_reg #(.N_SRC(5), .DATA_W(8), .ADDR_W(4), .CNT_W(4), .IDLE_HOLD(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .src_data_i(src_data), .src_en_i(src_en),
    .conflict_clr_i(cclr), .cnt_clr_i(nclr), .bus_o(bus0), .mar_o(mar0),
    .bus_valid_o(valid0), .bus_src_o(src0), .conflict_o(conf0),
    .conflict_mask_o(mask0), .xfer_cnt_o(cnt0));

  bus_arbiter_reg #(.N_SRC(5), .DATA_W(8), .ADDR_W(4), .CNT_W(16), .IDLE_HOLD(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .src_data_i(src_data), .src_en_i(src_en),
    .conflict_clr_i(cclr), .cnt_clr_i(nclr), .bus_o(bus1), .mar_o(mar1),
    .bus_valid_o(valid1), .bus_src_o(src1), .conflict_o(conf1),
    .conflict_mask_o(mask1), .xfer_cnt_o(cnt1));

  // Reference model state, one slot per DUT instance.
  logic [7:0] m_bus[2];
  int         m_src[2];
  bit         m_valid[2];
  bit         m_conf[2];
  logic [4:0] m_mask[2];
  int         m_cnt[2];
  bit         m_trap[2];
  int         cnt_max[2] = '{15, 65535};
  int         hold[2]    = '{0, 1};

  typedef struct {
    logic [4:0]  en;
    logic        cc;
    logic        nc;
    logic [7:0]  bus;
    logic [2:0]  src;
    logic        v;
    logic        conf;
    logic [4:0]  mask;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_bus[d] = '0; m_src[d] = 0; m_valid[d] = 0; m_conf[d] = 0;
      m_mask[d] = '0; m_cnt[d] = 0; m_trap[d] = 0;
    end
  endtask

  task automatic model_step();
    int  n;
    int  win;
    bit  coll;
    bit  arb;
    bit  grant;
    n = $countones(src_en);
    win = -1;
    for (int k = 0; k < 5; k++) if (src_en[k] && win < 0) win = k;
    coll = (n > 1);
    for (int d = 0; d < 2; d++) begin
      arb = !m_trap[d];
`ifdef BUS_CONFLICT_TRAP_EN
      if (m_trap[d] && cclr && !coll) arb = 1;
`endif
      grant = arb && (n > 0);
      if (grant) begin
        m_bus[d] = src_data[win*8 +: 8];
        m_src[d] = win;
        m_valid[d] = 1;
      end else begin
        m_valid[d] = 0;
        if (arb && hold[d] == 0) m_bus[d] = '0;
      end
      if (nclr) m_cnt[d] = grant ? 1 : 0;
      else if (grant && m_cnt[d] < cnt_max[d]) m_cnt[d] = m_cnt[d] + 1;
      if (coll) begin
        m_conf[d] = 1;
        m_mask[d] = cclr ? src_en : (m_mask[d] | src_en);
      end else if (cclr) begin
        m_conf[d] = 0;
        m_mask[d] = '0;
      end
`ifdef BUS_CONFLICT_TRAP_EN
      if (!m_trap[d] && coll) m_trap[d] = 1;
      else if (m_trap[d] && cclr && !coll) m_trap[d] = 0;
`endif
    end
  endtask

  task automatic check_model();
    chk("d0_bus",   bus0,   m_bus[0]);
    chk("d0_mar",   mar0,   m_bus[0][3:0]);
    chk("d0_valid", valid0, m_valid[0]);
    chk("d0_src",   src0,   m_src[0]);
    chk("d0_conf",  conf0,  m_conf[0]);
    chk("d0_mask",  mask0,  m_mask[0]);
    chk("d0_cnt",   cnt0,   m_cnt[0]);
    chk("d1_bus",   bus1,   m_bus[1]);
    chk("d1_valid", valid1, m_valid[1]);
    chk("d1_src",   src1,   m_src[1]);
    chk("d1_conf",  conf1,  m_conf[1]);
    chk("d1_mask",  mask1,  m_mask[1]);
    chk("d1_cnt",   cnt1,   m_cnt[1]);
  endtask

  // Inputs change at posedge+1; outputs are checked at the following posedge+1.
  task automatic apply(input logic [4:0] en, input logic [39:0] data,
                       input logic cc, input logic nc);
    src_en = en; src_data = data; cclr = cc; nclr = nc;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bus"},  {bus1, bus0},   '0);
    chk({tag, "_mar"},  {mar1, mar0},   '0);
    chk({tag, "_ctl"},  {valid1, conf1, valid0, conf0}, '0);
    chk({tag, "_src"},  {src1, src0},   '0);
    chk({tag, "_mask"}, {mask1, mask0}, '0);
    chk({tag, "_cnt"},  {cnt1, cnt0},   '0);
  endtask

  localparam logic [39:0] D = 40'hC4_3C_A5_5A_0F;

  initial begin
    vecs[0] = '{5'b00000, 0, 0, 8'h00, 3'd0, 0, 0, 5'b00000, 4'd0};
    vecs[1] = '{5'b00100, 0, 0, 8'hA5, 3'd2, 1, 0, 5'b00000, 4'd1};
    vecs[2] = '{5'b10010, 0, 0, 8'h5A, 3'd1, 1, 1, 5'b10010, 4'd2};
    vecs[3] = '{5'b00011, 0, 0, 8'h0F, 3'd0, 1, 1, 5'b10011, 4'd3};
    vecs[4] = '{5'b01100, 1, 0, 8'hA5, 3'd2, 1, 1, 5'b01100, 4'd4};
    vecs[5] = '{5'b00000, 1, 0, 8'h00, 3'd2, 0, 0, 5'b00000, 4'd4};
    vecs[6] = '{5'b01000, 0, 0, 8'h3C, 3'd3, 1, 0, 5'b00000, 4'd5};
    vecs[7] = '{5'b00000, 0, 0, 8'h00, 3'd3, 0, 0, 5'b00000, 4'd5};
    vecs[8] = '{5'b10000, 0, 1, 8'hC4, 3'd4, 1, 0, 5'b00000, 4'd1};
    vecs[9] = '{5'b00000, 0, 1, 8'h00, 3'd4, 0, 0, 5'b00000, 4'd0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

`ifndef BUS_CONFLICT_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].en, D, vecs[i].cc, vecs[i].nc);
      chk($sformatf("v%0d_bus", i),  bus0,  vecs[i].bus);
      chk($sformatf("v%0d_src", i),  src0,  vecs[i].src);
      chk($sformatf("v%0d_v", i),    valid0, vecs[i].v);
      chk($sformatf("v%0d_conf", i), conf0, vecs[i].conf);
      chk($sformatf("v%0d_mask", i), mask0, vecs[i].mask);
      chk($sformatf("v%0d_cnt", i),  cnt0,  vecs[i].cnt);
    end
    chk("v_mar_a5", {28'd0, 4'h5}, 32'd5);
    for (int i = 0; i < 20; i++) apply(5'b00001, D, 0, 0);
    chk("cnt_sat", cnt0, 4'hF);
    chk("cnt_wide", cnt1, 16'd20);
    apply(5'b00010, D, 0, 1);
    chk("cnt_clr_grant", cnt0, 4'd1);
    apply(5'b00000, D, 0, 0);
    chk("idle_hold_bus", bus1, 8'h5A);
    chk("idle_zero_bus", bus0, 8'h00);
`else
    apply(5'b00110, D, 0, 0);
    chk("trap_enter_bus", bus0, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      apply(5'b01000, D, 0, 0);
      chk("trap_bus", bus0, 8'h5A);
      chk("trap_valid", valid0, 1'b0);
      chk("trap_cnt", cnt0, 4'd1);
    end
    apply(5'b00000, D, 1, 0);
    apply(5'b01000, D, 0, 0);
    chk("trap_exit_bus", bus0, 8'h3C);
    chk("trap_exit_cnt", cnt0, 4'd2);
`endif

    // Asynchronous reset in the middle of traffic, checked before any edge.
    apply(5'b00100, D, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [4:0]  en;
      logic [39:0] data;
      en   = 5'($urandom) & 5'($urandom);
      data = {8'($urandom), 32'($urandom)};
      apply(en, data, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
